// File: rtl/hazard_detect_if.sv
// hazard_detect_if: ID-stage request bundle into the hazard unit and the stall
// reply back to the PC stage.
//   master : ID stage side  (drives id_* / flush_i, samples haz_o)
//   slave  : hazard_detect  (samples id_* / flush_i, drives haz_o)
interface hazard_detect_if;
    logic       id_valid_i;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic       id_rs_use_i;
    logic       id_rt_use_i;
    logic [4:0] id_rd_i;
    logic       id_wr_en_i;
    logic       id_is_load_i;
    logic       flush_i;
    logic       haz_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i,
               id_rd_i, id_wr_en_i, id_is_load_i, flush_i,
        input  haz_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i,
               id_rd_i, id_wr_en_i, id_is_load_i, flush_i,
        output haz_o
    );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: load-use / RAW interlock for the 5-stage pipeline.
// Tracks in-flight writers in a shift-register scoreboard (slot 0 = EX ...
// slot DEPTH-1 = WB) and raises a combinational stall toward the PC stage
// while the ID instruction reads a register still owned by a blocking writer.
//
// Ports:
//   clk_i        clock, all state on posedge
//   rst          synchronous active-high reset
//   id_bus       hazard_detect_if.slave: ID instruction fields, flush_i, haz_o
//   sb_busy_o    any scoreboard slot valid
//   stall_cnt_o  saturating count of stall cycles
//
// Optional feature macro HAZ_FWD_EN:
//   defined   -> downstream forwarding exists; only loads in the youngest
//                LOAD_GAP slots block
//   undefined -> full interlock; any matching writer in any slot blocks
module hazard_detect #(
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_GAP = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst,
    hazard_detect_if.slave   id_bus,
    output logic             sb_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned RW = 5;

    typedef struct packed {
        logic          valid;
        logic          is_load;
        logic [RW-1:0] rd;
    } sb_entry_t;

    // Elaboration-time parameter legality
    if (DEPTH < 1 || DEPTH > 8 || LOAD_GAP < 1 || LOAD_GAP > DEPTH) begin : g_bad_param
        $error("hazard_detect: illegal DEPTH/LOAD_GAP");
    end

    sb_entry_t        slot_q [DEPTH];
    logic [DEPTH-1:0] match;
    logic [DEPTH-1:0] slot_valid;
    logic             conflict;
    logic             haz;
    logic             issue;
    logic             push;

    // Per-slot source match; r0 is hard-wired and never creates a dependency
    always_comb begin
        match      = '0;
        slot_valid = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot_valid[k] = slot_q[k].valid;
            match[k] = slot_q[k].valid && (slot_q[k].rd != RW'(0)) &&
                       ((id_bus.id_rs_use_i && (id_bus.id_rs_i == slot_q[k].rd)) ||
                        (id_bus.id_rt_use_i && (id_bus.id_rt_i == slot_q[k].rd)));
        end
    end

    // Which matches actually block issue
    always_comb begin
        conflict = 1'b0;
`ifdef HAZ_FWD_EN
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((k < LOAD_GAP) && slot_q[k].is_load && match[k]) begin
                conflict = 1'b1;
            end
        end
`else
        conflict = |match;
`endif
    end

    // Flush wins over conflict: the discarded instruction never stalls
    assign haz   = id_bus.id_valid_i && !id_bus.flush_i && conflict;
    assign issue = id_bus.id_valid_i && !haz && !id_bus.flush_i;
    assign push  = issue && id_bus.id_wr_en_i && (id_bus.id_rd_i != RW'(0));

    assign id_bus.haz_o = haz;
    assign sb_busy_o    = |slot_valid;

    // Scoreboard advances every cycle, stalled or not; a stall inserts a bubble
    always_ff @(posedge clk_i) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
                slot_q[k] <= slot_q[k-1];
            end
            if (push) begin
                slot_q[0] <= '{valid: 1'b1, is_load: id_bus.id_is_load_i, rd: id_bus.id_rd_i};
            end else begin
                slot_q[0] <= '0;
            end
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk_i) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (haz && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule
